// File: rtl/bias_stream_sink.sv
// bias_stream_sink: receives streamed bias/weight beats over valid/ready,
// packs them into a register store and flags each completed tensor.
// Read-back is a two-stage registered port (address -> s1 -> rd_q).
module bias_stream_sink #(
    parameter int unsigned BIAS_TENSOR_SIZE_DIM_0 = 32,
    parameter int unsigned BIAS_TENSOR_SIZE_DIM_1 = 1,
    parameter int unsigned BIAS_PRECISION_0       = 16,
    parameter int unsigned BIAS_PRECISION_1       = 3,
    parameter int unsigned BIAS_PARALLELISM_DIM_0 = 1,
    parameter int unsigned BIAS_PARALLELISM_DIM_1 = 1,
    parameter int unsigned IN_DEPTH               = BIAS_TENSOR_SIZE_DIM_0 / BIAS_PARALLELISM_DIM_0,
    parameter int unsigned AWIDTH                 = $clog2(IN_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BIAS_PRECISION_0-1:0] data_in [BIAS_PARALLELISM_DIM_0-1:0],
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    input  logic                        reload,
    output logic                        loaded,
    output logic                        frame_done,
    input  logic [AWIDTH-1:0]           rd_addr,
    input  logic                        rd_ce,
    output logic [BIAS_PRECISION_0-1:0] rd_q [BIAS_PARALLELISM_DIM_0-1:0]
);

    localparam int unsigned PAR = BIAS_PARALLELISM_DIM_0;
    localparam int unsigned W   = BIAS_PRECISION_0;
    // Beat-index width; kept at least 1 so IN_DEPTH=1 still elaborates.
    localparam int unsigned IW  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

    localparam logic [IW-1:0]     LAST_BEAT = IW'(IN_DEPTH - 1);
    localparam logic [AWIDTH-1:0] DEPTH_A   = AWIDTH'(IN_DEPTH);

    localparam bit CFG_OK = (BIAS_TENSOR_SIZE_DIM_1 == 1) &&
                            (BIAS_PARALLELISM_DIM_1 == 1) &&
                            (BIAS_PRECISION_1 <= BIAS_PRECISION_0) &&
                            ((BIAS_TENSOR_SIZE_DIM_0 % BIAS_PARALLELISM_DIM_0) == 0);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("bias_stream_sink: unsupported parameter combination");
        end
    endgenerate

    typedef enum logic {
        LOAD,
        HOLD
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] beat_cnt, cnt_next;
    logic          accept;
    logic          done_next;

    logic [W-1:0]  store [IN_DEPTH][PAR];
    logic [W-1:0]  s1    [PAR-1:0];

    assign data_in_ready = (state == LOAD);
    assign loaded        = (state == HOLD);

    // Next-state logic: reload wins, otherwise a LOAD-state transfer advances the count.
    always_comb begin
        state_next = state;
        cnt_next   = beat_cnt;
        accept     = 1'b0;
        done_next  = 1'b0;
        if (reload) begin
            state_next = LOAD;
            cnt_next   = '0;
        end else if ((state == LOAD) && data_in_valid) begin
            accept = 1'b1;
            if (beat_cnt == LAST_BEAT) begin
                cnt_next   = '0;
                state_next = HOLD;
                done_next  = 1'b1;
            end else begin
                cnt_next = beat_cnt + IW'(1);
            end
        end
    end

    // State, beat counter and completion pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LOAD;
            beat_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            beat_cnt   <= cnt_next;
            frame_done <= done_next;
        end
    end

    generate
        for (genvar e = 0; e < int'(IN_DEPTH); e++) begin : g_entry
            for (genvar k = 0; k < int'(PAR); k++) begin : g_lane
                // Store entry e, lane k: written when the accepted beat targets this entry.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        store[e][k] <= '0;
                    end else if (accept && (beat_cnt == IW'(e))) begin
                        store[e][k] <= data_in[k];
                    end
                end
            end
        end

        for (genvar k = 0; k < int'(PAR); k++) begin : g_rd
            // Read pipeline for lane k: s1 samples the store (old value on a same-edge write), rd_q follows s1.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1[k]   <= '0;
                    rd_q[k] <= '0;
                end else if (rd_ce) begin
                    s1[k]   <= (rd_addr >= DEPTH_A) ? '0 : store[rd_addr[IW-1:0]][k];
                    rd_q[k] <= s1[k];
                end
            end
        end
    endgenerate

endmodule

// File: doc/bias_stream_sink.md
# bias_stream_sink

Receiving end of the parameter-streaming interface: accepts bias/weight beats over a valid/ready stream, packs them into an internal register store, and flags completion of each full tensor. Sits where a streamed parameter tensor is loaded at run time instead of baked into a ROM. A registered read-back port, 2-cycle latency, matches the ROM-style `address0/ce0/q0` access used by the parameter sources.

## Interface
- `BIAS_TENSOR_SIZE_DIM_0`, 32: elements per tensor (dim 0).
- `BIAS_TENSOR_SIZE_DIM_1`, 1: must be 1; other values unsupported.
- `BIAS_PRECISION_0`, 16: element width in bits.
- `BIAS_PRECISION_1`, 3: fractional bits. Informational only; no arithmetic.
- `BIAS_PARALLELISM_DIM_0`, 1: lanes per beat (PAR). Must divide DIM_0.
- `BIAS_PARALLELISM_DIM_1`, 1: must be 1.
- `IN_DEPTH`, DIM_0/PAR: beats per tensor (derived).
- `AWIDTH`, $clog2(IN_DEPTH)+1: read-address width (derived).
- `clk` in 1: single clock. All logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `data_in` in PAR×BIAS_PRECISION_0 (unpacked array [PAR-1:0]): lane k = element beat*PAR+k.
- `data_in_valid` in 1: beat present.
- `data_in_ready` out 1: sink accepts the beat.
- `reload` in 1: single-cycle pulse; restart loading from element 0.
- `loaded` out 1: a complete tensor is held.
- `frame_done` out 1: one-cycle pulse on acceptance of the final beat.
- `rd_addr` in AWIDTH: beat index to read.
- `rd_ce` in 1: read-pipeline enable.
- `rd_q` out PAR×BIAS_PRECISION_0 (unpacked array): read data.

## Operation
- FSM states:
  - LOAD: `data_in_ready`=1. Registered state decode only; no combinational path from any input.
  - HOLD: `data_in_ready`=0, `loaded`=1.
- Handshake: a beat transfers on a rising edge with `data_in_valid` && `data_in_ready`. On transfer:
  - store lane k at entry beat_cnt*PAR+k;
  - increment beat_cnt.
- Final beat: a transfer with beat_cnt==IN_DEPTH-1 does all of the following in the same edge:
  - writes the data;
  - sets beat_cnt to 0;
  - moves to HOLD;
  - asserts `frame_done` for one cycle;
  - sets `loaded`=1.
- `reload` high at an edge takes priority over everything:
  - sets state to LOAD, beat_cnt to 0 and `loaded` to 0;
  - drops any beat presented in that cycle (not written, not counted);
  - leaves store contents unchanged;
  - suppresses `frame_done` even when that beat was the final beat.
- `data_in_valid` in HOLD is ignored; the source must hold its beat.
- Read-back:
  - stage 1: `rd_ce` high loads s1 from beat `rd_addr` (PAR lanes), or all-zero when rd_addr ≥ IN_DEPTH;
  - stage 2: `rd_ce` high copies s1 into `rd_q`;
  - with `rd_ce` low, both stages hold.
- Read/write collision on the same entry in one edge: the read captures the old (pre-write) value.
- Reads are allowed in any state. During LOAD, entries from the previous tensor are visible until overwritten.

## Timing
- Reset asserted, asynchronously:
  - state=LOAD, beat_cnt=0, `loaded`=0, `frame_done`=0;
  - s1=0, `rd_q`=0, all store entries=0.
- After reset release, `data_in_ready`=1 from the first cycle.
- Throughput is one beat per cycle in LOAD, so a tensor loads in IN_DEPTH back-to-back cycles.
- `frame_done` is asserted in the cycle after the final-beat edge. `loaded` rises in the same cycle and `data_in_ready` falls in the same cycle.
- Read latency: data for `rd_addr` presented at edge N, with `rd_ce` high at edges N and N+1, appears on `rd_q` after edge N+1.
- A write at edge N is visible to a read sampled at edge N+1 or later.
- Reset mid-load: the store is cleared and the partial tensor is discarded; the next load starts at element 0.
- IN_DEPTH=1: every accepted beat is a final beat.

## Test plan
- Reset, then stream 8 beats (DIM_0=32, PAR=4), lane values 0x0000..0x001F in order, valid held high -> `data_in_ready` high for 8 cycles then low, `frame_done` pulses exactly once, `loaded`=1; read-back of addr 0..7 returns {0x3,0x2,0x1,0x0}..{0x1F,0x1E,0x1D,0x1C} with 2-cycle latency.
- Random valid gaps (~50%) while streaming the same 8 beats -> same stored contents, exactly 8 transfers counted, one `frame_done`.
- In HOLD, hold valid with data 0xFFFF -> no write, store unchanged; pulse `reload` -> `loaded`=0, ready=1 next cycle; a new 8-beat load of 0x1000+i overwrites all entries.
- `reload` coinciding with the 3rd beat of a load -> that beat is dropped, beat_cnt=0, no `frame_done`; the next transfer lands at entries 0..3.
- Read addr 2 in the same edge as the beat-2 write -> returns the old value; the next read of addr 2 returns the new value. Read addr 8 -> `rd_q` all zero.
- Assert `rst` low asynchronously mid-load after 5 beats -> outputs at reset values immediately; after release, read-back of all addresses returns 0.
